// File: rtl/sram_arb_pkg.sv
// Purpose : shared types and constants for the two-port SRAM arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Purpose : pick the winning port from two requests and a priority pointer.
// Latency : combinational.
// Backpressure: none; the caller only samples the result in IDLE.
//
// Ports:
//   req0, req1 : request (re|we) from port 0 / port 1
//   prio       : port that wins when both request at once
//   any        : at least one port is requesting
//   win        : index of the winning port (only meaningful when any=1)
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic any,
  output logic win
);

  always_comb begin
    any = req0 | req1;
    win = PORT0;
    if (req0 && req1) begin
      win = prio;
    end else if (req1) begin
      win = PORT1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Purpose : share one SRAM controller between the MEM stage (port 0) and a
//           secondary master (port 1).
// Latency : grant on the sampling edge, 4 enabled cycles, 1 release cycle.
// Backpressure: pN_ready stays low while a port's request is pending and
//               not yet completing; requesters hold their request until then.
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 always wins a tie.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   pN_addr/pN_wdata      : requester address / write data
//   pN_re/pN_we           : requester read / write request (we wins if both)
//   pN_rdata/pN_ready     : read data / not-stalled to requester
//   m_addr/m_wdata        : latched address / write data to controller
//   m_re/m_we             : controller enables, high only in BUSY
//   m_rdata/m_ready       : controller read data / completion
//   busy, gnt             : arbiter occupied / index of the granted port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_re,
  input  logic              p0_we,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,

  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_re,
  input  logic              p1_we,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,

  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_re,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,

  output logic              busy,
  output logic              gnt
);

  state_t            state_q, state_d;
  logic              gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic req0, req1;
  logic any_req, win;
  logic prio;
  logic in_busy, done, rd_done;

  assign req0 = p0_re | p0_we;
  assign req1 = p1_re | p1_we;

`ifdef SRAM_ARB_RR_EN
  // Holds the port that wins the next tie; flipped away from each winner.
  logic prio_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PORT0;
    end else if (state_q == ST_IDLE && any_req) begin
      prio_q <= ~win;
    end
  end

  assign prio = prio_q;
`else
  assign prio = PORT0;
`endif

  sram_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio),
    .any  (any_req),
    .win  (win)
  );

  assign in_busy = (state_q == ST_BUSY);
  assign done    = in_busy & m_ready;
  assign rd_done = done & (op_q == OP_READ);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (any_req) state_d = ST_BUSY;
      ST_BUSY:    if (m_ready) state_d = ST_RELEASE;
      // One idle cycle with enables low lets the controller's counter clear.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Transaction latch: captured only when a grant is made in IDLE, so a
  // request withdrawn mid-BUSY cannot disturb the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= PORT0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (state_q == ST_IDLE && any_req) begin
      gnt_q <= win;
      if (win == PORT1) begin
        addr_q  <= p1_addr;
        wdata_q <= p1_wdata;
        op_q    <= p1_we ? OP_WRITE : OP_READ;
      end else begin
        addr_q  <= p0_addr;
        wdata_q <= p0_wdata;
        op_q    <= p0_we ? OP_WRITE : OP_READ;
      end
    end
  end

  // Per-port read data hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rd_done) begin
      if (gnt_q == PORT1) begin
        rdata1_q <= m_rdata;
      end else begin
        rdata0_q <= m_rdata;
      end
    end
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_re    = in_busy & (op_q == OP_READ);
  assign m_we    = in_busy & (op_q == OP_WRITE);

  assign busy = (state_q == ST_BUSY) | (state_q == ST_RELEASE);
  assign gnt  = gnt_q;

  assign p0_ready = ~req0 | (done & (gnt_q == PORT0));
  assign p1_ready = ~req1 | (done & (gnt_q == PORT1));

  // Granted port sees the controller data directly while BUSY so the value
  // is valid in the same cycle that ready rises.
  assign p0_rdata = (in_busy && gnt_q == PORT0) ? m_rdata : rdata0_q;
  assign p1_rdata = (in_busy && gnt_q == PORT1) ? m_rdata : rdata1_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 18, SRAM word address width.
REQ-002 Parameter: DATA_W, 32, requester data width (two 16-bit SRAM words).
REQ-003 clk  in  1  clock; all state SHALL change on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 p0_addr/p1_addr  in  ADDR_W  requester address; port 0 = MEM stage, port 1 = secondary master.
REQ-006 p0_wdata/p1_wdata  in  DATA_W  requester write data.
REQ-007 p0_re/p1_re, p0_we/p1_we  in  1  requester read/write request, held until pN_ready seen high.
REQ-008 p0_rdata/p1_rdata  out  DATA_W  read data to requester.
REQ-009 p0_ready/p1_ready  out  1  high = port not stalled.
REQ-010 m_addr  out  ADDR_W, m_wdata  out  DATA_W, m_re  out  1, m_we  out  1  to SRAM controller.
REQ-011 m_rdata  in  DATA_W, m_ready  in  1  from SRAM controller; m_ready goes high on the 4th consecutive enabled cycle.
REQ-012 busy  out  1  high in BUSY or RELEASE; gnt  out  1  index of port granted.

Function
REQ-013 FSM states IDLE, BUSY, RELEASE SHALL be used.
REQ-014 IDLE: if any port requests (re|we), pick winner, latch its addr, wdata, op and index, go BUSY next edge; else stay IDLE.
REQ-015 Op latched SHALL be write if we=1 (we has precedence when re and we are both high), else read.
REQ-016 BUSY: m_re/m_we driven from latched op, m_addr/m_wdata from latched values; stay until m_ready=1, then go RELEASE.
REQ-017 RELEASE: m_re=m_we=0 for exactly one cycle so the controller counter clears; then IDLE.
REQ-018 m_re, m_we SHALL be 0 in IDLE and RELEASE; m_addr/m_wdata hold latched values in all states.
REQ-019 pN_ready = ~(pN_re|pN_we) | (state==BUSY & gnt==N & m_ready), combinational.
REQ-020 Latency: request sampled in IDLE at cycle 0 -> m_re/m_we high cycles 1-4 -> pN_ready high cycle 4 -> RELEASE cycle 5 -> IDLE cycle 6.
REQ-021 pN_rdata SHALL equal m_rdata while gnt==N in BUSY; per-port register captures m_rdata on the completion cycle of a read and drives pN_rdata otherwise.
REQ-022 Losing port SHALL see pN_ready=0 until served; request withdrawn while not granted SHALL be dropped silently.
REQ-023 Request withdrawn mid-BUSY SHALL NOT abort; the latched transaction completes.
REQ-024 Default arbitration: fixed priority, port 0 wins simultaneous requests.

Reset
REQ-025 rst SHALL force IDLE, gnt=0, latched addr/wdata/op=0, rdata registers=0, RR pointer=0 at next edge, including mid-BUSY.
REQ-026 After reset: m_re=m_we=0, busy=0, pN_ready=1 when port idle.

Configuration
REQ-027 SRAM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not served last wins; pointer updates on each grant.
REQ-028 SRAM_ARB_RR_EN undefined: fixed priority per REQ-024; no pointer register.

Structure
REQ-029 Package sram_arb_pkg SHALL hold state enum, ADDR_W/DATA_W defaults, port-index constants.
REQ-030 One sub-module sram_arb_pick SHALL compute winner from two requests and RR pointer.

Verification
REQ-031 p0 read addr 0x00010 at cycle 0, m_rdata=0xDEADBEEF -> m_re cycles 1-4, p0_ready=1 cycle 4, p0_rdata=0xDEADBEEF thereafter.
REQ-032 p0 we+re both high, addr 0x3FFFF, wdata 0x12345678 -> only m_we asserted, m_addr=0x3FFFF, m_wdata=0x12345678.
REQ-033 p0,p1 request same cycle, fixed priority -> gnt=0 first, p1 served from cycle 6, p1_ready=1 cycle 10.
REQ-034 With SRAM_ARB_RR_EN, repeated simultaneous requests -> grants alternate 0,1,0,1.
REQ-035 rst asserted in BUSY cycle 2 -> cycle 3 m_re=m_we=0, busy=0, gnt=0.
REQ-036 p1 drops request during p0 BUSY -> no p1 transaction, IDLE reached cycle 6.
